// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory
// (one request in flight) into a small FIFO that feeds the IF/ID register.
module instr_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
  localparam int         PTR_W     = $clog2(DEPTH),
  localparam int         CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [63:0]      redirect_pc,
  output logic             imem_req,
  output logic [63:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [63:0]      out_pc,
  output logic [CNT_W-1:0] count,
  output logic             halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [63:0]     fetch_pc;
  logic            drop;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [31:0]     instr_mem [DEPTH];
  logic [63:0]     pc_mem    [DEPTH];

  logic issue;
  logic enq;
  logic deq;
  logic not_full;

  assign not_full  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign halted    = (state == HALT);
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'd0;
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 64'd0;

  // Redirect flushes the queue, so it overrides any dequeue in the same cycle.
  assign deq = out_valid && out_ready && !redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    enq        = 1'b0;
    case (state)
      IDLE: begin
        if (!redirect && not_full) begin
          issue      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        // A redirect without a response keeps us waiting for the stale reply.
        if (imem_rvalid) begin
          next_state = IDLE;
          if (!redirect && !drop) begin
            enq = 1'b1;
            if (imem_rdata == HALT_WORD) begin
              next_state = HALT;
            end
          end
        end
      end
      HALT: begin
        if (redirect) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop <= 1'b0;
    end else if (state == WAIT) begin
      if (imem_rvalid) begin
        drop <= 1'b0;
      end else if (redirect) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc  <= 64'd0;
      imem_req  <= 1'b0;
      imem_addr <= 64'd0;
    end else begin
      imem_req <= issue;
      if (redirect) begin
        fetch_pc <= redirect_pc & ~64'h3;
      end else if (issue) begin
        fetch_pc  <= fetch_pc + 64'd4;
        imem_addr <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= imem_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic [2:0]  count;
  logic        halted;

  instr_prefetch_queue #(.DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  // Reference model: a plain FIFO of fetched entries plus fetch bookkeeping.
  entry_t      mq[$];
  logic [63:0] m_fpc, m_addr;
  bit          m_busy, m_discard, m_halted, m_req;

  int          compared = 0;
  int          mismatched = 0;
  int          wait_cnt = 0;
  logic [63:0] halt_addr = 64'hFFFF_FFFF_FFFF_FFF0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == halt_addr) return HALT;
    if (a == 64'd0) return 32'h00000013;
    if (a == 64'd4) return 32'h00100093;
    return {a[31:2], 2'b11} ^ 32'h12340000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_fpc = '0; m_addr = '0;
    m_busy = 0; m_discard = 0; m_halted = 0; m_req = 0;
  endtask

  task automatic model_edge();
    int sz;
    entry_t e;
    sz = mq.size();
    m_req = 0;
    if (redirect) begin
      mq.delete();
      m_fpc = redirect_pc & ~64'h3;
      m_halted = 0;
      if (m_busy) begin
        if (imem_rvalid) begin m_busy = 0; m_discard = 0; end
        else m_discard = 1;
      end
    end else begin
      if (out_ready && sz != 0) void'(mq.pop_front());
      if (m_busy) begin
        if (imem_rvalid) begin
          if (!m_discard) begin
            e.pc = m_addr; e.instr = imem_rdata;
            mq.push_back(e);
            if (imem_rdata == HALT) m_halted = 1;
          end
          m_busy = 0; m_discard = 0;
        end
      end else if (!m_halted && sz < DEPTH) begin
        m_req = 1; m_addr = m_fpc; m_fpc = m_fpc + 64'd4; m_busy = 1;
      end
    end
  endtask

  task automatic checkOutput();
    chk("out_valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("out_pc", out_pc, mq.size() != 0 ? mq[0].pc : 64'd0);
    chk("out_instr", out_instr, mq.size() != 0 ? mq[0].instr : 32'd0);
    chk("halted", halted, m_halted);
    chk("imem_req", imem_req, m_req);
    chk("imem_addr", imem_addr, m_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    checkOutput();
    if (m_req) wait_cnt = 0;
    else wait_cnt++;
  endtask

  task automatic applyStimulus(input int lat, input bit rdy);
    redirect = 0;
    out_ready = rdy;
    if (m_busy && wait_cnt >= lat) begin
      imem_rvalid = 1; imem_rdata = mem_word(m_addr);
    end else begin
      imem_rvalid = 0; imem_rdata = 32'h0;
    end
    tick();
  endtask

  task automatic redirect_step(input logic [63:0] pc);
    redirect = 1; redirect_pc = pc; imem_rvalid = 0; out_ready = 0;
    tick();
    redirect = 0;
  endtask

  initial begin
    int n;
    int cmax;
    rst = 0; redirect = 0; redirect_pc = '0; out_ready = 0;
    imem_rvalid = 0; imem_rdata = '0;
    model_reset();
    #12;
    checkOutput();
    rst = 1;

    // Reset release, 1-cycle memory latency, consumer always ready.
    cmax = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1);
      if (count > cmax) cmax = count;
    end
    chk("first_pc", out_pc, 64'd0);
    chk("first_instr", out_instr, 32'h00000013);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1);
      if (count > cmax) cmax = count;
    end
    chk("second_pc", out_pc, 64'd4);
    chk("second_instr", out_instr, 32'h00100093);
    chk("count_le1", cmax <= 1, 1);

    // Stalled consumer: queue fills to DEPTH and fetching stops.
    redirect_step(64'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0);
      if (imem_req) n++;
    end
    chk("fill_reqs", n, 4);
    chk("fill_count", count, 4);
    chk("fill_req_low", imem_req, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    chk("refill_req", imem_req, 1);
    chk("refill_addr", imem_addr, 64'd16);

    // Redirect while the request for 8 is outstanding.
    redirect_step(64'd0);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(3, 0);
      if (m_busy && m_addr == 64'd8) break;
    end
    chk("addr8", imem_addr, 64'd8);
    redirect_step(64'h40);
    chk("redir_count", count, 0);
    chk("redir_valid", out_valid, 0);
    imem_rvalid = 1; imem_rdata = mem_word(64'd8);
    tick();
    chk("drop_count", count, 0);
    applyStimulus(3, 0);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 64'h40);

    // HALT word at 0x0C stops fetching until a redirect.
    redirect_step(64'd0);
    halt_addr = 64'h0C;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0);
      if (imem_req) n++;
    end
    chk("halt_reqs", n, 4);
    chk("halt_flag", halted, 1);
    chk("halt_count", count, 4);
    redirect_step(64'd0);
    halt_addr = 64'hFFFF_FFFF_FFFF_FFF0;
    chk("unhalt", halted, 0);
    applyStimulus(1, 0);
    chk("unhalt_req", imem_req, 1);
    chk("unhalt_addr", imem_addr, 64'd0);

    // Redirect coincident with a response while two entries are queued.
    redirect_step(64'd0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(2, 0);
      if (mq.size() == 2 && m_busy && wait_cnt >= 2) break;
    end
    chk("pre_count", count, 2);
    redirect = 1; redirect_pc = 64'h200; out_ready = 1;
    imem_rvalid = 1; imem_rdata = mem_word(m_addr);
    tick();
    redirect = 0;
    chk("coinc_count", count, 0);
    applyStimulus(2, 0);
    applyStimulus(2, 0);

    // Asynchronous reset in the middle of a WAIT.
    #2 rst = 0;
    #1;
    model_reset();
    wait_cnt = 0;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_halted", halted, 0);
    @(negedge clk);
    rst = 1; imem_rvalid = 1; imem_rdata = 32'h0BADF00D;
    tick();
    imem_rvalid = 0;
    chk("late_count", count, 0);
    chk("post_rst_req", imem_req, 1);
    chk("post_rst_addr", imem_addr, 64'd0);

    // Fetch address wraps at the top of the 64-bit space.
    redirect_step(64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 24) == 0);
      redirect_pc = {$urandom, $urandom};
      imem_rvalid = m_busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      imem_rdata  = ($urandom_range(0, 19) == 0) ? HALT : $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
